dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port word-addressed data memory (combinational read, write on posedge clk).
- Master 0 is the CPU load/store port; master 1 is a secondary bus master (DMA/peripheral loader).
- Grants at most one access per cycle using round-robin priority.
- Returns a registered ack and read data one cycle after the access, and flags misaligned or out-of-range addresses without touching memory.

Parameters:
- RAM_SIZE, 256, memory depth in 32-bit words; a word index of addr[31:2] >= RAM_SIZE is out of range.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 access request, held high until m0_ack
- m0_wr  in  1  master 0 direction: 1 = write, 0 = read
- m0_addr  in  32  master 0 byte address, must be word aligned
- m0_wdata  in  32  master 0 write data
- m0_ack  out  1  master 0 access complete, one-cycle pulse
- m0_err  out  1  master 0 error, valid with m0_ack
- m0_rdata  out  32  master 0 read data, valid with m0_ack
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: identical to the m0 ports, for master 1
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational)

Behaviour:
- Reset (asynchronous): mX_ack=0, mX_err=0, mX_rdata=0, prio=0. mem_rd and mem_wr are forced to 0 while reset is high, regardless of clock.
- Eligibility: master X is eligible in a cycle when mX_req=1 and mX_ack=0. This keeps a request still held during its ack cycle from being serviced twice.
- Selection (combinational, same cycle):
  - only one master eligible: that master wins.
  - both eligible: the master indicated by prio wins.
  - none eligible: idle; mem_rd=mem_wr=0, and mem_addr/mem_wdata are don't-care (drive 0).
- Address check on the winner:
  - bad = (addr[1:0] != 0) or (addr[31:2] >= RAM_SIZE).
  - bad: mem_rd=mem_wr=0; no memory access occurs.
- Memory drive for a good access: mem_addr = winner addr; mem_wdata = winner wdata; mem_wr = winner wr; mem_rd = !winner wr.
- Registered outputs at the posedge ending a grant cycle N, visible in cycle N+1:
  - winner's ack = 1.
  - winner's err = bad.
  - winner's rdata = mem_rdata for a good read; 0 for a write or a bad access.
- Writes land in memory at the same posedge as the grant (zero added write latency). Read latency from grant to ack is 1 cycle.
- Non-winners: ack=0 and err=0 next cycle. rdata holds its last value.
- Ack is a single-cycle pulse; it deasserts the following cycle unless the master is granted again.
- prio update: after any grant, prio = the index of the non-winner. On an idle cycle, prio is unchanged.
- Throughput:
  - one master streaming alone is granted at most every other cycle (ack-cycle exclusion).
  - two masters streaming interleave for one access per cycle total.
- Requesters must hold wr/addr/wdata stable from req assertion until ack. Dropping req before ack is allowed only if no grant occurred; behaviour otherwise is undefined.
- Reset mid-operation: a grant in progress is discarded. A write whose posedge coincides with reset assertion may still commit in memory, because reset gates mem_wr asynchronously only once it is asserted. No ack is delivered; a requester still holding req is re-arbitrated from prio=0 after release.
- No combinational path from mem_rdata to mX_ack or mX_err.

Test Plan:
- Reset then idle (both req=0 for 5 cycles) -> mem_rd=mem_wr=0 every cycle; all acks 0; prio stays 0.
- m0 write 0x12345678 to addr 0x10, then read addr 0x10 -> write ack at cycle 1 with err=0; read ack with m0_rdata=0x12345678, exactly 1 cycle after its grant.
- m0 and m1 both hold req (reads of 0x20 and 0x24, preloaded 0xA, 0xB) from the same cycle after reset -> m0 granted first (ack m0 rdata=0xA), next cycle m1 (ack m1 rdata=0xB), continuous alternation with one mem access per cycle.
- m1 reads addr 0x402 (misaligned), then addr 0x400 with RAM_SIZE=256 -> m1_ack=1, m1_err=1, m1_rdata=0 for each; mem_rd/mem_wr never asserted.
- m0 holds req continuously for 6 cycles, m1 idle -> grants on cycles 0, 2, 4 only; m0_ack pulses on cycles 1, 3, 5; no double access.
- Assert reset asynchronously mid-cycle while m1 read is granted -> m1_ack and mem_rd drop immediately; after release with req still high, m1 is re-granted and acked with the correct data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-master arbiter for a single-port word memory
// Registered ack/err/rdata one cycle after the grant; bad addresses never reach memory.
module dmem_arbiter #(
  parameter int RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0] LP_WORDS = 30'(RAM_SIZE);

  logic        r_prio;
  logic        r_m0_ack;
  logic        r_m0_err;
  logic [31:0] r_m0_rdata;
  logic        r_m1_ack;
  logic        r_m1_err;
  logic [31:0] r_m1_rdata;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_grant;
  logic        w_win1;
  logic        w_win0;
  logic        w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_bad;
  logic        w_go;
  logic [31:0] w_rd_result;

  // A master sitting in its ack cycle is not eligible, so a held req is not serviced twice.
  always_comb begin
    w_elig0 = m0_req & ~r_m0_ack;
    w_elig1 = m1_req & ~r_m1_ack;
    w_grant = w_elig0 | w_elig1;
    w_win1  = w_elig1 & (~w_elig0 | r_prio);
    w_win0  = w_grant & ~w_win1;
  end

  always_comb begin
    w_wr    = w_win1 ? m1_wr    : m0_wr;
    w_addr  = w_win1 ? m1_addr  : m0_addr;
    w_wdata = w_win1 ? m1_wdata : m0_wdata;
    w_bad   = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= LP_WORDS);
    w_go    = w_grant & ~w_bad;
  end

  // Strobes are gated by reset directly so they drop the instant reset rises.
  assign mem_rd    = w_go & ~w_wr & ~reset;
  assign mem_wr    = w_go &  w_wr & ~reset;
  assign mem_addr  = w_go ? w_addr  : 32'h0;
  assign mem_wdata = w_go ? w_wdata : 32'h0;

  assign w_rd_result = (w_go & ~w_wr) ? mem_rdata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio     <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= 32'h0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= 32'h0;
    end else begin
      r_m0_ack <= w_win0;
      r_m0_err <= w_win0 & w_bad;
      r_m1_ack <= w_win1;
      r_m1_err <= w_win1 & w_bad;
      if (w_win0) begin
        r_m0_rdata <= w_rd_result;
      end
      if (w_win1) begin
        r_m1_rdata <= w_rd_result;
      end
      // Priority passes to whichever master lost (or did not ask).
      if (w_grant) begin
        r_prio <= ~w_win1;
      end
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m0_err   = r_m0_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_ack   = r_m1_ack;
  assign m1_err   = r_m1_err;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
// Stimulus pushes expected responses; a negedge monitor pops on every ack.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.RAM_SIZE(256)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0_ack) begin
      if (q0.size() == 0) chk("m0 unexpected ack", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("m0 err", {31'd0, m0_err}, {31'd0, e.err});
        chk("m0 rdata", m0_rdata, e.rdata);
      end
    end
    if (m1_ack) begin
      if (q1.size() == 0) chk("m1 unexpected ack", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("m1 err", {31'd0, m1_err}, {31'd0, e.err});
        chk("m1 rdata", m1_rdata, e.rdata);
      end
    end
  end

  task automatic push_exp(input int m, input logic err, input logic [31:0] rd);
    exp_t e;
    e.err = err;
    e.rdata = rd;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input int m, input logic req, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Single access from one master; waits for ack with a bound and optionally checks latency.
  task automatic access(input int m, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rd, input int exp_lat, input bit quiet);
    int  lat;
    bit  got;
    push_exp(m, exp_err, exp_rd);
    @(posedge clk); #1;
    drive(m, 1'b1, wr, addr, wdata);
    if (quiet) begin
      #2;
      chk("mem strobes on bad addr", {30'd0, mem_rd, mem_wr}, 32'd0);
    end
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) got = 1;
    end
    if (!got) chk("ack timeout", 32'd0, 32'd1);
    else if (exp_lat > 0) chk("ack latency", lat, exp_lat);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'h0000_000A;
    mem[9] = 32'h0000_000B;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset m0_rdata", m0_rdata, 32'h0);
    chk("reset m1_err", {31'd0, m1_err}, 32'd0);
    reset = 1'b0;

    // Idle: nothing may reach memory
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle mem strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
      chk("idle acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    end

    // Both request together: m0 first (prio still 0), then strict alternation
    push_exp(0, 1'b0, 32'hA); push_exp(0, 1'b0, 32'hA);
    push_exp(1, 1'b0, 32'hB); push_exp(1, 1'b0, 32'hB);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h24, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt mem_rd", {31'd0, mem_rd}, 32'd1);
      chk("alt mem_addr", mem_addr, (i % 2 == 0) ? 32'h20 : 32'h24);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // m0 write then read back
    access(0, 1'b1, 32'h10, 32'h1234_5678, 1'b0, 32'h0, 1, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678, 1, 1'b0);

    // m1 misaligned and out-of-range reads
    access(1, 1'b0, 32'h402, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    access(1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    access(1, 1'b1, 32'h3FC, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 1'b0);
    access(0, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 1'b0);

    // m0 streaming alone: grants every other cycle
    repeat (3) push_exp(0, 1'b0, 32'h1234_5678);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream mem_rd", {31'd0, mem_rd}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("stream m0_ack", {31'd0, m0_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // Asynchronous reset during an m1 read grant
    push_exp(1, 1'b0, 32'hB);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h24, 32'h0);
    #2;
    chk("pre-reset mem_rd", {31'd0, mem_rd}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("async reset m1_ack", {31'd0, m1_ack}, 32'd0);
    @(posedge clk); #1;
    chk("in-reset m1_ack", {31'd0, m1_ack}, 32'd0);
    #2;
    reset = 1'b0;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge clk); #1;
        if (m1_ack) got = 1;
      end
      if (!got) chk("re-grant ack timeout", 32'd0, 32'd1);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    chk("m0 queue drained", q0.size(), 32'd0);
    chk("m1 queue drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
